// File: rtl/sddr_pkg.sv
// Shared DDR3 init-sequencer types: FSM state encoding and {ras_n,cas_n,we_n} command encodings.
package sddr_pkg;

  typedef enum logic [3:0] {
    RST_HOLD = 4'd0,
    CKE_WAIT = 4'd1,
    XPR_WAIT = 4'd2,
    MRS2     = 4'd3,
    MRS3     = 4'd4,
    MRS1     = 4'd5,
    MRS0     = 4'd6,
    ZQCL     = 4'd7,
    ZQ_WAIT  = 4'd8,
    READY    = 4'd9
  } state_t;

  typedef logic [2:0] rcw_t;

  localparam rcw_t RCW_NOP  = 3'b111;
  localparam rcw_t RCW_MRS  = 3'b000;
  localparam rcw_t RCW_ZQCL = 3'b110;

  function automatic int max_int(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/sddr_param_check.sv
// Elaboration-time guard on the init timing parameters; every wait must last at least one cycle.
module sddr_param_check #(
  parameter int T_RESET_CYC  = 1,
  parameter int T_CKE_CYC    = 1,
  parameter int T_XPR_CYC    = 1,
  parameter int T_MRD_CYC    = 1,
  parameter int T_ZQINIT_CYC = 1
) ();

  if ((T_RESET_CYC < 1) || (T_CKE_CYC < 1) || (T_XPR_CYC < 1) ||
      (T_MRD_CYC < 1) || (T_ZQINIT_CYC < 1)) begin : g_bad_timing
    $error("sddr_phy_init_cmd: all timing parameters must be >= 1");
  end

endmodule

// File: rtl/sddr_wait_counter.sv
// Shared wait-state down-counter: reloaded on state entry, parks at zero.
module sddr_wait_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_r;

  // Load takes priority; otherwise count down until zero and hold there
  always_ff @(posedge clk) begin
    if (load) begin
      cnt_r <= value;
    end else if (cnt_r != {WIDTH{1'b0}}) begin
      cnt_r <= cnt_r - WIDTH'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/sddr_phy_init_cmd.sv
// DDR3 PHY power-up sequencer (reset, CKE, MRS2/3/1/0, ZQCL) followed by a
// one-cycle-latency controller command pass-through once READY.
module sddr_phy_init_cmd
  import sddr_pkg::*;
#(
  parameter int BANK_BITS    = 3,
  parameter int ROW_BITS     = 13,
  parameter int T_RESET_CYC  = 40000,
  parameter int T_CKE_CYC    = 100000,
  parameter int T_XPR_CYC    = 72,
  parameter int T_MRD_CYC    = 4,
  parameter int T_ZQINIT_CYC = 512,
  parameter logic [ROW_BITS-1:0] MR0 = {ROW_BITS{1'b0}},
  parameter logic [ROW_BITS-1:0] MR1 = {ROW_BITS{1'b0}},
  parameter logic [ROW_BITS-1:0] MR2 = {ROW_BITS{1'b0}},
  parameter logic [ROW_BITS-1:0] MR3 = {ROW_BITS{1'b0}}
) (
  input  logic                 in_ddr_clock_i,
  input  logic                 in_phy_reset_p_i,
  input  logic                 reinit_i,
  output logic                 init_done_o,
  output logic                 ck_en_o,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [2:0]           cmd_rcw_i,
  input  logic [BANK_BITS-1:0] cmd_ba_i,
  input  logic [ROW_BITS-1:0]  cmd_addr_i,
  output logic                 ddr3_reset_n_o,
  output logic                 ddr3_cke_o,
  output logic                 ddr3_cs_n_o,
  output logic                 ddr3_ras_n_o,
  output logic                 ddr3_cas_n_o,
  output logic                 ddr3_we_n_o,
  output logic [BANK_BITS-1:0] ddr3_ba_o,
  output logic [ROW_BITS-1:0]  ddr3_addr_o
);

  localparam int T_MAX = max_int(max_int(max_int(T_RESET_CYC, T_CKE_CYC),
                                         max_int(T_XPR_CYC, T_MRD_CYC)), T_ZQINIT_CYC);
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] LD_RESET = CNT_W'(T_RESET_CYC - 1);
  localparam logic [CNT_W-1:0] LD_CKE   = CNT_W'(T_CKE_CYC - 1);
  localparam logic [CNT_W-1:0] LD_XPR   = CNT_W'(T_XPR_CYC - 1);
  localparam logic [CNT_W-1:0] LD_MRD   = CNT_W'(T_MRD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_ZQ    = CNT_W'(T_ZQINIT_CYC - 1);

  state_t               state_r;
  state_t               nxt_state_s;
  logic                 load_s;
  logic                 zero_s;
  logic                 enter_s;
  logic                 cmd_acc_s;
  logic [CNT_W-1:0]     load_val_s;
  rcw_t                 rcw_r;
  logic [BANK_BITS-1:0] ba_r;
  logic [ROW_BITS-1:0]  addr_r;

  sddr_param_check #(
    .T_RESET_CYC (T_RESET_CYC),
    .T_CKE_CYC   (T_CKE_CYC),
    .T_XPR_CYC   (T_XPR_CYC),
    .T_MRD_CYC   (T_MRD_CYC),
    .T_ZQINIT_CYC(T_ZQINIT_CYC)
  ) u_param_check ();

  sddr_wait_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk  (in_ddr_clock_i),
    .load (load_s),
    .value(load_val_s),
    .zero (zero_s)
  );

  // Next-state selection and the wait length to load for the state being entered
  always_comb begin
    nxt_state_s = state_r;
    load_val_s  = LD_RESET;
    if (in_phy_reset_p_i) begin
      nxt_state_s = RST_HOLD;
    end else begin
      case (state_r)
        RST_HOLD: if (zero_s) begin nxt_state_s = CKE_WAIT; load_val_s = LD_CKE; end else nxt_state_s = RST_HOLD;
        CKE_WAIT: if (zero_s) begin nxt_state_s = XPR_WAIT; load_val_s = LD_XPR; end else nxt_state_s = CKE_WAIT;
        XPR_WAIT: if (zero_s) begin nxt_state_s = MRS2;     load_val_s = LD_MRD; end else nxt_state_s = XPR_WAIT;
        MRS2:     if (zero_s) begin nxt_state_s = MRS3;     load_val_s = LD_MRD; end else nxt_state_s = MRS2;
        MRS3:     if (zero_s) begin nxt_state_s = MRS1;     load_val_s = LD_MRD; end else nxt_state_s = MRS3;
        MRS1:     if (zero_s) begin nxt_state_s = MRS0;     load_val_s = LD_MRD; end else nxt_state_s = MRS1;
        MRS0:     if (zero_s) nxt_state_s = ZQCL; else nxt_state_s = MRS0;
        ZQCL:     begin nxt_state_s = ZQ_WAIT; load_val_s = LD_ZQ; end
        ZQ_WAIT:  if (zero_s) nxt_state_s = READY; else nxt_state_s = ZQ_WAIT;
        READY:    if (reinit_i) nxt_state_s = RST_HOLD; else nxt_state_s = READY;
        default:  nxt_state_s = RST_HOLD;
      endcase
    end
  end

  assign enter_s     = (nxt_state_s != state_r);
  assign load_s      = in_phy_reset_p_i || enter_s;
  assign cmd_ready_o = (state_r == READY) && !reinit_i;
  assign cmd_acc_s   = cmd_ready_o && cmd_valid_i;

  // State register plus pin flops; pin values reflect the state being entered
  always_ff @(posedge in_ddr_clock_i) begin
    if (in_phy_reset_p_i) begin
      state_r        <= RST_HOLD;
      ddr3_reset_n_o <= 1'b0;
      ddr3_cke_o     <= 1'b0;
      ck_en_o        <= 1'b0;
      init_done_o    <= 1'b0;
      rcw_r          <= RCW_NOP;
      ba_r           <= {BANK_BITS{1'b0}};
      addr_r         <= {ROW_BITS{1'b0}};
    end else begin
      state_r        <= nxt_state_s;
      ddr3_reset_n_o <= (nxt_state_s != RST_HOLD);
      ddr3_cke_o     <= (nxt_state_s != RST_HOLD) && (nxt_state_s != CKE_WAIT);
      ck_en_o        <= (nxt_state_s != RST_HOLD);
      init_done_o    <= (nxt_state_s == READY);
      rcw_r          <= RCW_NOP;
      ba_r           <= {BANK_BITS{1'b0}};
      addr_r         <= {ROW_BITS{1'b0}};
      if (cmd_acc_s) begin
        rcw_r  <= cmd_rcw_i;
        ba_r   <= cmd_ba_i;
        addr_r <= cmd_addr_i;
      end else if (enter_s) begin
        // Only the first cycle of an MRS/ZQCL state carries the command
        case (nxt_state_s)
          MRS2:    begin rcw_r <= RCW_MRS; ba_r <= BANK_BITS'(2'd2); addr_r <= MR2; end
          MRS3:    begin rcw_r <= RCW_MRS; ba_r <= BANK_BITS'(2'd3); addr_r <= MR3; end
          MRS1:    begin rcw_r <= RCW_MRS; ba_r <= BANK_BITS'(2'd1); addr_r <= MR1; end
          MRS0:    begin rcw_r <= RCW_MRS; ba_r <= BANK_BITS'(2'd0); addr_r <= MR0; end
          ZQCL:    begin rcw_r <= RCW_ZQCL; addr_r[10] <= 1'b1; end
          default: rcw_r <= RCW_NOP;
        endcase
      end else begin
        rcw_r <= RCW_NOP;
      end
    end
  end

  assign ddr3_cs_n_o  = 1'b0;
  assign ddr3_ras_n_o = rcw_r[2];
  assign ddr3_cas_n_o = rcw_r[1];
  assign ddr3_we_n_o  = rcw_r[0];
  assign ddr3_ba_o    = ba_r;
  assign ddr3_addr_o  = addr_r;

endmodule

// File: doc/sddr_phy_init_cmd.md
SDDR_PHY_INIT_CMD -- requirements
Module: sddr_phy_init_cmd

Interface
REQ-001 SHALL have parameters (name, default, meaning), one per line:
  BANK_BITS 3 bank address width
  ROW_BITS 13 address bus width
  T_RESET_CYC 40000 reset_n low hold, cycles
  T_CKE_CYC 100000 reset_n high to CKE high, cycles
  T_XPR_CYC 72 CKE high to first MRS, cycles
  T_MRD_CYC 4 MRS to next command, cycles
  T_ZQINIT_CYC 512 ZQCL to ready, cycles
  MR0..MR3 ROW_BITS-wide mode register values, default 0
REQ-002 SHALL have ports (name, direction, width, meaning), one per line:
  in_ddr_clock_i in 1 sole clock, all logic rising-edge
  in_phy_reset_p_i in 1 reset, synchronous, active-high
  reinit_i in 1 single-cycle request to rerun init from READY
  init_done_o out 1 high only in READY
  ck_en_o out 1 enable for the external differential clock generator
  cmd_valid_i in 1 controller command valid
  cmd_ready_o out 1 command accepted when valid&&ready
  cmd_rcw_i in 3 {ras_n,cas_n,we_n} from controller
  cmd_ba_i in BANK_BITS bank
  cmd_addr_i in ROW_BITS address
  ddr3_reset_n_o, ddr3_cke_o, ddr3_cs_n_o, ddr3_ras_n_o, ddr3_cas_n_o, ddr3_we_n_o out 1 each, registered DRAM control pins
  ddr3_ba_o out BANK_BITS registered bank
  ddr3_addr_o out ROW_BITS registered address

Function
REQ-003 All DRAM outputs SHALL be driven from flops; ddr3_cs_n_o SHALL be constant 0.
REQ-004 FSM states SHALL be: RST_HOLD, CKE_WAIT, XPR_WAIT, MRS2, MRS3, MRS1, MRS0, ZQCL, ZQ_WAIT, READY.
REQ-005 RST_HOLD: reset_n=0, cke=0, ck_en=0; SHALL stay exactly T_RESET_CYC cycles, then go to CKE_WAIT.
REQ-006 CKE_WAIT: reset_n=1, cke=0, ck_en=1; T_CKE_CYC cycles, then XPR_WAIT.
REQ-007 XPR_WAIT: cke=1, NOP (rcw=111); T_XPR_CYC cycles, then MRS2.
REQ-008 Each MRSn state SHALL issue one MRS cycle (rcw=000, ba=n, addr=MRn), then NOP for T_MRD_CYC-1 cycles; order MRS2->MRS3->MRS1->MRS0->ZQCL.
REQ-009 ZQCL SHALL issue one cycle rcw=110, addr[10]=1, other addr bits 0, ba=0, then go to ZQ_WAIT; ZQ_WAIT holds NOP for T_ZQINIT_CYC cycles, then READY.
REQ-010 In all non-command cycles before READY, rcw SHALL be 111 and ba/addr SHALL be 0.
REQ-011 READY: init_done_o=1; cmd_ready_o = !reinit_i (combinational); on acceptance the command SHALL appear on the pins the next cycle (latency 1), for exactly one cycle; with no accepted command pins SHALL show NOP.
REQ-012 cmd_ready_o SHALL be 0 in every state other than READY; cmd_valid_i is ignored there.
REQ-013 reinit_i in READY SHALL win over a simultaneous cmd_valid_i (command not accepted) and go to RST_HOLD next cycle; reinit_i outside READY SHALL be ignored.
REQ-014 One shared down-counter SHALL time all waits, width $clog2(max timing parameter + 1); loaded on state entry, the transition fires at count 0; a parameter value of 1 SHALL produce a single-cycle state.
REQ-015 Timing parameters SHALL be >=1; violation SHALL be flagged by an elaboration-time assertion.

Reset
REQ-016 While in_phy_reset_p_i is high, on each clock: state=RST_HOLD, counter=T_RESET_CYC-1, reset_n=0, cke=0, ck_en=0, rcw=111, ba=0, addr=0, init_done=0, cmd_ready=0.
REQ-017 Reset asserted mid-sequence or in READY SHALL abort at the next edge with the REQ-016 values; no partial command SHALL be emitted.

Structure
REQ-018 Command encodings (NOP, MRS, ZQCL, rcw type) and the FSM state enum SHALL live in package sddr_pkg.
REQ-019 The wait counter SHALL be a sub-module sddr_wait_counter (load, value, zero flag).

Verification
REQ-020 Params T_RESET=3, T_CKE=5, T_XPR=2, T_MRD=2, T_ZQINIT=4: release reset -> reset_n rises at cycle 3, cke at cycle 8, MRS2 at cycle 10, init_done at cycle 23.
REQ-021 MR0=0x0123, MR1=0x0044, MR2=0x0008, MR3=0 -> pins show ba 2,3,1,0 with those addr values, each separated by one NOP.
REQ-022 In READY, valid with rcw=101, ba=5, addr=0x0400 -> pins show it on the following cycle only, then NOP.
REQ-023 reinit_i and cmd_valid_i same cycle in READY -> no command emitted, reset_n=0 next cycle, init reruns.
REQ-024 Reset pulse during MRS1 -> next cycle reset_n=0, cke=0, rcw=111; full sequence restarts.
REQ-025 All timing params =1 -> every wait state lasts exactly one cycle, no hang.
